// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data memory between the CPU data port (m0) and the
// debug/program loader (m1).
//
// Grants are combinational: the winner's fields drive dm_* in the same cycle and DMEM
// writes on the clock edge. Ties in ARB are round-robin. An m1 grant with m1_lock=1
// moves to LOCK1, where m1 has exclusive ownership until it drops m1_lock. Byte addresses
// are rebased from BASE and range-checked. Each grant produces a one-cycle registered
// response on the granted port: rvalid, rdata (read data or 0) and err (out of range).
//
// Build option: define DMEM_ARB_MMIO_EN to add mmio_seg, a 32-bit register at byte
// address BASE+DEPTH_BYTES that drives the 7-segment display. Without it, that address is
// out of range like any other.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   m{0,1}_req/we/addr/wdata/be    request fields, held stable until gnt
//   m1_lock                        loader asks for exclusive ownership
//   m{0,1}_gnt                     request accepted this cycle (combinational)
//   m{0,1}_rvalid/rdata/err        registered response, one cycle after gnt
//   dm_ena/w/r/addr/wdata/byteena  DMEM control, valid in the grant cycle
//   dm_rdata                       DMEM read data, combinational from dm_addr
//   mmio_seg                       display register (DMEM_ARB_MMIO_EN only)
module dmem_arbiter #(
  parameter logic [31:0] BASE        = 32'h1001_0000,
  parameter int unsigned DEPTH_BYTES = 2048,
  parameter int unsigned ADDR_W      = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_be,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
`ifdef DMEM_ARB_MMIO_EN
  output logic [31:0]       mmio_seg,
`endif
  output logic              dm_ena,
  output logic              dm_w,
  output logic              dm_r,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_byteena,
  input  logic [31:0]       dm_rdata
);

  typedef enum logic {StArb, StLock1} state_e;

  state_e state_q, state_d;
  logic   last_m1_q, last_m1_d;  // 1: m1 won the last grant, so m0 wins the next tie

  logic        rvalid0_q, rvalid1_q;
  logic        err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;

  logic        gnt0, gnt1, any_gnt;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata, off;
  logic [3:0]  sel_be;
  logic        in_range, mmio_hit;
  logic [31:0] rsp_data;
  logic        rsp_err;

  // Arbitration and lock FSM
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_d   = state_q;
    last_m1_d = last_m1_q;
    unique case (state_q)
      StArb: begin
        if (m0_req && m1_req) begin
          gnt0 = last_m1_q;
          gnt1 = ~last_m1_q;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
        // Lock is only honoured when m1 actually wins in ARB.
        if (rst && gnt1 && m1_lock) state_d = StLock1;
      end
      StLock1: begin
        gnt1 = m1_req;
        if (!m1_lock) state_d = StArb;
      end
      default: state_d = StArb;
    endcase
    // No grants while reset is held.
    gnt0 = gnt0 & rst;
    gnt1 = gnt1 & rst;
    if (gnt0) last_m1_d = 1'b0;
    if (gnt1) last_m1_d = 1'b1;
    // Leaving LOCK1 hands the next tie to the CPU.
    if (state_q == StLock1 && !m1_lock) last_m1_d = 1'b1;
  end

  assign any_gnt = gnt0 | gnt1;
  assign m0_gnt  = gnt0;
  assign m1_gnt  = gnt1;

  // Winner mux and address decode
  always_comb begin
    sel_we    = gnt1 ? m1_we    : m0_we;
    sel_addr  = gnt1 ? m1_addr  : m0_addr;
    sel_wdata = gnt1 ? m1_wdata : m0_wdata;
    sel_be    = gnt1 ? m1_be    : m0_be;
    // Modulo subtraction: addresses below BASE wrap high and fail the range check.
    off       = sel_addr - BASE;
    in_range  = off < 32'(DEPTH_BYTES);
`ifdef DMEM_ARB_MMIO_EN
    mmio_hit  = off == 32'(DEPTH_BYTES);
`else
    mmio_hit  = 1'b0;
`endif
  end

  always_comb begin
    dm_ena      = any_gnt & in_range;
    dm_w        = dm_ena & sel_we;
    dm_r        = dm_ena & ~sel_we;
    dm_addr     = dm_ena ? off[ADDR_W-1:0] : '0;
    dm_wdata    = dm_ena ? sel_wdata : 32'h0;
    dm_byteena  = dm_ena ? sel_be : 4'h0;
  end

`ifdef DMEM_ARB_MMIO_EN
  logic [31:0] mmio_q, mmio_d;

  always_comb begin
    mmio_d = mmio_q;
    if (any_gnt && mmio_hit && sel_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) mmio_d[8*b +: 8] = sel_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mmio_q <= 32'h0;
    else      mmio_q <= mmio_d;
  end

  assign mmio_seg = mmio_q;
`endif

  // Response contents for the current grant
  always_comb begin
    rsp_data = 32'h0;
    rsp_err  = ~(in_range | mmio_hit);
    if (!sel_we) begin
      if (in_range) begin
        rsp_data = dm_rdata;
      end
`ifdef DMEM_ARB_MMIO_EN
      else if (mmio_hit) begin
        rsp_data = mmio_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StArb;
      last_m1_q <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      err0_q    <= gnt0 & rsp_err;
      err1_q    <= gnt1 & rsp_err;
      // rdata holds between responses.
      if (gnt0) rdata0_q <= rsp_data;
      if (gnt1) rdata1_q <= rsp_data;
    end
  end

  assign m0_rvalid = rvalid0_q;
  assign m0_rdata  = rdata0_q;
  assign m0_err    = err0_q;
  assign m1_rvalid = rvalid1_q;
  assign m1_rdata  = rdata1_q;
  assign m1_err    = err1_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter/sequencer placed in front of the single data memory (DMEM) in the single-cycle/pipelined computer top.
- Shares DMEM between requester 0 (CPU data port) and requester 1 (debug/program loader).
- Translates byte addresses from the data segment base to DMEM offsets and range-checks them.
- Returns registered read data with a valid strobe; a lock mode lets requester 1 own the memory for bursts.

Parameters:
- BASE, 32'h1001_0000, byte address of DMEM offset 0.
- DEPTH_BYTES, 2048, DMEM size in bytes; offsets >= DEPTH_BYTES are out of range.
- ADDR_W, 11, width of dm_addr; must satisfy 2^ADDR_W >= DEPTH_BYTES.

Ports:
- clk  input  1  system clock (divided CPU clock)
- rst  input  1  asynchronous reset, active-low
- m0_req  input  1  CPU access request
- m0_we  input  1  1 = write, 0 = read
- m0_addr  input  32  CPU byte address
- m0_wdata  input  32  CPU write data
- m0_be  input  4  CPU byte enables
- m0_gnt  output  1  CPU request accepted this cycle
- m0_rvalid  output  1  response valid (one cycle after grant)
- m0_rdata  output  32  read data, valid with m0_rvalid
- m0_err  output  1  out-of-range flag, valid with m0_rvalid
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0_*, for the loader
- m1_lock  input  1  loader requests exclusive ownership
- dm_ena  output  1  DMEM enable
- dm_w  output  1  DMEM write strobe
- dm_r  output  1  DMEM read strobe
- dm_addr  output  ADDR_W  DMEM byte offset
- dm_wdata  output  32  DMEM write data
- dm_byteena  output  4  DMEM byte enables
- dm_rdata  input  32  DMEM read data, combinational from dm_addr

Behaviour:
- Reset (rst=0, async):
  - all gnt/rvalid/err = 0, rdata = 0; dm_* strobes = 0.
  - FSM = ARB; last-winner pointer = 1, so m0 wins the first tie.
  - Any in-flight response is dropped; no rvalid after reset release.
- Grant is combinational within the cycle; at most one gnt high per cycle.
  - The granted requester's fields drive dm_* that same cycle; DMEM writes on clk edge.
- FSM states:
  - ARB:
    - only one req → grant it.
    - both req → grant the one not granted last; pointer updates on every grant.
    - m1 granted with m1_lock=1 → next state LOCK1.
  - LOCK1:
    - only m1 eligible; m0_gnt = 0 regardless of m0_req.
    - stays while m1_lock=1; m1_lock=0 → ARB next cycle, and the pointer is set so m0 wins the next tie.
    - m1_lock is ignored unless m1 is granted in ARB; lock with no req keeps ownership but performs no access.
- Address handling:
  - off = addr − BASE (32-bit modulo).
  - In range (off < DEPTH_BYTES): dm_addr = off[ADDR_W-1:0], dm_ena = 1, dm_w = we, dm_r = ~we, dm_byteena = be.
  - Out of range (includes addr < BASE, which wraps high): no DMEM strobe (dm_ena = dm_w = dm_r = 0); response has err = 1, rdata = 0.
- Response:
  - Registered; rvalid pulses exactly one cycle after gnt, on the granted port only, for both reads and writes.
  - Read: rdata = dm_rdata sampled at the grant edge.
  - Write: rdata = 0.
  - rdata holds its value until the next response.
- Back-to-back: a new grant may occur in the same cycle that the previous rvalid is high (throughput 1 access/cycle).
- A requester must hold req and fields stable until it sees gnt.
- No grant when neither requester asserts req; dm_* strobes = 0.

Optional Feature:
- Macro DMEM_ARB_MMIO_EN.
- Defined:
  - Adds output mmio_seg[31:0] (reset 0).
  - Writes to byte address BASE+DEPTH_BYTES (one word past DMEM) from either port update mmio_seg per byte enable, with err = 0.
  - Reads of that address return mmio_seg.
  - Intended to drive the 7-segment display.
- Undefined: the port is absent; that address is out of range like any other.

Test Plan:
- Reset then m0 read 0x1001_0010 with DMEM word 0xDEADBEEF → m0_gnt same cycle, dm_addr=0x010, dm_r=1; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m0_err=0.
- m0_req and m1_req both high for 4 cycles → grants alternate m0, m1, m0, m1; never both high; rvalid follows each grant by one cycle.
- m1 write with m1_lock=1 for 3 cycles while m0_req held → m0_gnt=0 through LOCK1; lock dropped → m0 granted the next cycle.
- m0 write 0x0FFF_FFF0 (below BASE) → no dm_w; next cycle m0_rvalid=1, m0_err=1, m0_rdata=0; same for 0x1001_0800.
- rst asserted low in the cycle after an m1 read grant → m1_rvalid stays 0; after release, a tie is granted to m0.
- With DMEM_ARB_MMIO_EN: m0 write 0x1001_0800 data 0x12345678 be=4'b0011 → mmio_seg=0x00005678, err=0, no dm_w.
